// File: rtl/mem_pkg.sv
// Shared types and constants for the data-RAM access controller.
// Contents: access size encodings, FSM state enum, default widths and a
// helper that classifies full-word accesses.
package mem_pkg;

   localparam int unsigned DEF_ADDR_W = 9;
   localparam int unsigned DEF_DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      CAP   = 3'd2,
      MERGE = 3'd3,
      WR    = 3'd4,
      RESP  = 3'd5
   } state_t;

   // Size 11 only reaches the datapath when error checking is off, where it acts as a word.
   function automatic logic is_word(input logic [1:0] size);
      return (size == SZ_WORD) || (size == SZ_ILL);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the data-RAM access controller.
// master: CPU datapath (drives req_*, receives req_ready and rsp_*).
// slave : mem_access_ctrl.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W+1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the data-RAM port.
// Ports: size/is_signed/offset select the lane; rdata is the RAM word;
// wdata is right-aligned store data; load_data_c is the extended load
// result; merge_data_c is rdata with the addressed lane replaced by wdata.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]            size,
   input  logic                  is_signed,
   input  logic [1:0]            offset,
   input  logic [DEF_DATA_W-1:0] rdata,
   input  logic [DEF_DATA_W-1:0] wdata,
   output logic [DEF_DATA_W-1:0] load_data_c,
   output logic [DEF_DATA_W-1:0] merge_data_c
);

   logic [4:0]            byte_sh;
   logic [4:0]            half_sh;
   logic [7:0]            byte_val;
   logic [15:0]           half_val;
   logic [DEF_DATA_W-1:0] mask;
   logic [DEF_DATA_W-1:0] lane;

   // Halfword lane uses only addr[1]; addr[0] is ignored (or trapped as an error upstream).
   assign byte_sh  = {offset, 3'b000};
   assign half_sh  = {offset[1], 4'b0000};
   assign byte_val = 8'(rdata >> byte_sh);
   assign half_val = 16'(rdata >> half_sh);

   // Load extract and extension
   always_comb begin
      load_data_c = rdata;
      case (size)
         SZ_BYTE: load_data_c = {{24{is_signed & byte_val[7]}}, byte_val};
         SZ_HALF: load_data_c = {{16{is_signed & half_val[15]}}, half_val};
         default: load_data_c = rdata;
      endcase
   end

   // Store merge: replace only the addressed lane
   always_comb begin
      mask         = '1;
      lane         = wdata;
      merge_data_c = wdata;
      case (size)
         SZ_BYTE: begin
            mask = DEF_DATA_W'(32'h0000_00FF) << byte_sh;
            lane = DEF_DATA_W'(wdata[7:0]) << byte_sh;
         end
         SZ_HALF: begin
            mask = DEF_DATA_W'(32'h0000_FFFF) << half_sh;
            lane = DEF_DATA_W'(wdata[15:0]) << half_sh;
         end
         default: begin
            mask = '1;
            lane = wdata;
         end
      endcase
      merge_data_c = (rdata & ~mask) | (lane & mask);
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the on-chip data RAM port: one load/store at a time,
// sub-word stores done as read-modify-write.
// Ports: clk, reset (sync, active-high); bus (slave modport: req_* in,
// req_ready/rsp_* out); ram_read/ram_write strobes, ram_addr word address,
// ram_data_in write data, ram_data_out registered RAM read data.
// Build option: define MEM_ACCESS_ERR_CHECK_EN to enable alignment and
// illegal-size checking with a one-cycle error response.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_ctrl_if.slave   bus,
   output logic               ram_read,
   output logic               ram_write,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_data_in,
   input  logic [DATA_W-1:0]  ram_data_out
);

   state_t            state;
   state_t            state_next;
   logic              accept_c;
   logic              req_err_c;
   logic              lat_write;
   logic              lat_signed;
   logic [1:0]        lat_size;
   logic [1:0]        lat_off;
   logic [DATA_W-1:0] lat_wdata;
   logic              ram_read_q;
   logic              ram_write_q;
   logic [DATA_W-1:0] load_data_c;
   logic [DATA_W-1:0] merge_data_c;

   assign accept_c = bus.req_valid && bus.req_ready;

   // Strobes are killed combinationally so a reset mid-transaction never touches RAM
   assign ram_read  = ram_read_q  & ~reset;
   assign ram_write = ram_write_q & ~reset;

   // Request error decode
`ifdef MEM_ACCESS_ERR_CHECK_EN
   always_comb begin
      req_err_c = 1'b0;
      case (bus.req_size)
         SZ_BYTE: req_err_c = 1'b0;
         SZ_HALF: req_err_c = bus.req_addr[0];
         SZ_WORD: req_err_c = (bus.req_addr[1:0] != 2'b00);
         default: req_err_c = 1'b1;
      endcase
   end
`else
   assign req_err_c = 1'b0;
`endif

   mem_lane_align u_align (
      .size         (lat_size),
      .is_signed    (lat_signed),
      .offset       (lat_off),
      .rdata        (ram_data_out),
      .wdata        (lat_wdata),
      .load_data_c  (load_data_c),
      .merge_data_c (merge_data_c)
   );

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (req_err_c)                  state_next = RESP;
               else if (!bus.req_write)        state_next = RD;
               else if (is_word(bus.req_size)) state_next = WR;
               else                            state_next = RD;
            end
         end
         RD:      state_next = lat_write ? MERGE : CAP;
         CAP:     state_next = RESP;
         MERGE:   state_next = WR;
         WR:      state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, request latch and registered outputs (decoded from the next state)
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         ram_read_q    <= 1'b0;
         ram_write_q   <= 1'b0;
         ram_addr      <= '0;
         ram_data_in   <= '0;
         lat_write     <= 1'b0;
         lat_signed    <= 1'b0;
         lat_size      <= SZ_BYTE;
         lat_off       <= 2'b00;
         lat_wdata     <= '0;
      end else begin
         state         <= state_next;
         bus.req_ready <= (state_next == IDLE);
         bus.rsp_valid <= (state_next == RESP);
         bus.rsp_err   <= (state == IDLE) && accept_c && req_err_c;
         bus.rsp_rdata <= (state == CAP) ? load_data_c : '0;
         ram_read_q    <= (state_next == RD);
         ram_write_q   <= (state_next == WR);
         if (accept_c) begin
            lat_write  <= bus.req_write;
            lat_signed <= bus.req_signed;
            lat_size   <= bus.req_size;
            lat_off    <= bus.req_addr[1:0];
            lat_wdata  <= bus.req_wdata;
            ram_addr   <= bus.req_addr[ADDR_W+1:2];
         end
         if (accept_c && bus.req_write && is_word(bus.req_size)) begin
            ram_data_in <= bus.req_wdata;
         end else if (state == MERGE) begin
            ram_data_in <= merge_data_c;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a registered-read RAM model.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   logic        clk;
   logic        reset;
   logic        ram_read;
   logic        ram_write;
   logic [8:0]  ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus ();

   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .ram_read     (ram_read),
      .ram_write    (ram_write),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model and bench-side preload port
   logic [31:0] mem [0:511];
   logic        pre_we = 1'b0;
   logic [8:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   logic [31:0] rd_q = '0;
   assign ram_data_out = rd_q;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (ram_write) mem[ram_addr] <= ram_data_in;
      if (ram_read) rd_q <= mem[ram_addr];
   end

   // Activity monitor
   int         cyc = 0;
   int         rd_cnt = 0;
   int         wr_cnt = 0;
   int         both_cnt = 0;
   int         rsp_cnt = 0;
   int         outst = 0;
   int         max_out = 0;
   logic [8:0] last_wr_addr = '0;

   always @(posedge clk) begin : mon
      int n;
      cyc <= cyc + 1;
      if (ram_read) rd_cnt <= rd_cnt + 1;
      if (ram_write) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= ram_addr;
      end
      if (ram_read && ram_write) both_cnt <= both_cnt + 1;
      if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
      n = outst + ((bus.req_valid && bus.req_ready) ? 1 : 0) - (bus.rsp_valid ? 1 : 0);
      if (reset) outst <= 0;
      else outst <= n;
      if (n > max_out) max_out <= n;
   end

   task automatic poke(input int a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = 9'(a);
      pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Drive one request; returns #1 after the acceptance edge
   task automatic accept_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [10:0] a, input logic [31:0] wd, output logic ok);
      ok = 1'b0;
      @(negedge clk);
      bus.req_write = w;
      bus.req_size = sz;
      bus.req_signed = sg;
      bus.req_addr = a;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (bus.req_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      bus.req_valid = 1'b0;
   endtask

   // Cycle 1 is the cycle right after the acceptance edge; lat=0 means no response
   task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
      int k;
      lat = 0;
      rd = '0;
      er = 1'b0;
      k = 1;
      while (lat == 0 && k <= 20) begin
         if (bus.rsp_valid === 1'b1) begin
            lat = k;
            rd = bus.rsp_rdata;
            er = bus.rsp_err;
         end else begin
            @(posedge clk);
            #1;
            k++;
         end
      end
   endtask

   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [10:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
      logic ok;
      accept_req(w, sz, sg, a, wd, ok);
      if (ok) wait_rsp(lat, rd, er);
      else begin
         lat = 0;
         rd = 'x;
         er = 1'bx;
      end
   endtask

   task automatic test_reset;
      @(posedge clk);
      #1;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++;
      if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rsp_rdata); end
      checks++;
      if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.rsp_err); end
      checks++;
      if ({ram_read, ram_write} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {ram_read, ram_write}); end
      checks++;
      if (ram_addr !== 9'h0 || ram_data_in !== 32'h0) begin
         errors++; $display("FAIL rst_ram_bus got addr %h data %h exp 0/0", ram_addr, ram_data_in);
      end
      checks++;
   endtask

   task automatic test_load;
      logic [10:0] ta [7] = '{11'h016, 11'h016, 11'h016, 11'h014, 11'h014, 11'h014, 11'h017};
      logic [1:0]  ts [7] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_WORD, SZ_BYTE};
      logic        tg [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] te [7] = '{32'hFFFF_FF99, 32'h0000_0099, 32'hFFFF_8899, 32'h0000_AABB,
                              32'hFFFF_FFBB, 32'h8899_AABB, 32'h0000_0088};
      int lat;
      logic [31:0] rd;
      logic er;
      int rs;
      poke(5, 32'h8899_AABB);
      for (int i = 0; i < 7; i++) begin
         rs = rd_cnt;
         run_req(1'b0, ts[i], tg[i], ta[i], 32'h0, lat, rd, er);
         if (rd !== te[i] || er !== 1'b0) begin
            errors++; $display("FAIL load_%0d_data got %h err %b exp %h err 0", i, rd, er, te[i]);
         end
         checks++;
         if (lat !== 3) begin errors++; $display("FAIL load_%0d_latency got %0d exp 3", i, lat); end
         checks++;
         if (rd_cnt - rs !== 1) begin errors++; $display("FAIL load_%0d_reads got %0d exp 1", i, rd_cnt - rs); end
         checks++;
      end
   endtask

   task automatic test_word_store;
      int lat;
      logic [31:0] rd;
      logic er;
      int rs, ws;
      rs = rd_cnt;
      ws = wr_cnt;
      run_req(1'b1, SZ_WORD, 1'b0, 11'h010, 32'hDEAD_BEEF, lat, rd, er);
      if (lat !== 2) begin errors++; $display("FAIL wst_latency got %0d exp 2", lat); end
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL wst_rsp got %h err %b exp 0 err 0", rd, er); end
      checks++;
      if (wr_cnt - ws !== 1 || rd_cnt - rs !== 0) begin
         errors++; $display("FAIL wst_strobes got wr %0d rd %0d exp 1/0", wr_cnt - ws, rd_cnt - rs);
      end
      checks++;
      if (last_wr_addr !== 9'd4) begin errors++; $display("FAIL wst_addr got %0d exp 4", last_wr_addr); end
      checks++;
      run_req(1'b0, SZ_WORD, 1'b0, 11'h010, 32'h0, lat, rd, er);
      if (rd !== 32'hDEAD_BEEF || lat !== 3) begin
         errors++; $display("FAIL wst_readback got %h lat %0d exp deadbeef lat 3", rd, lat);
      end
      checks++;
   endtask

   task automatic test_subword_store;
      int lat;
      logic [31:0] rd;
      logic er;
      int rs, ws;
      poke(4, 32'h1122_3344);
      rs = rd_cnt;
      ws = wr_cnt;
      run_req(1'b1, SZ_HALF, 1'b0, 11'h012, 32'h0000_CAFE, lat, rd, er);
      @(negedge clk);
      if (lat !== 4) begin errors++; $display("FAIL hst_latency got %0d exp 4", lat); end
      checks++;
      if (mem[4] !== 32'hCAFE_3344) begin errors++; $display("FAIL hst_word got %h exp cafe3344", mem[4]); end
      checks++;
      if (rd_cnt - rs !== 1 || wr_cnt - ws !== 1) begin
         errors++; $display("FAIL hst_strobes got rd %0d wr %0d exp 1/1", rd_cnt - rs, wr_cnt - ws);
      end
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL hst_rsp got %h err %b exp 0 err 0", rd, er); end
      checks++;
      run_req(1'b1, SZ_BYTE, 1'b0, 11'h011, 32'h1234_565A, lat, rd, er);
      @(negedge clk);
      if (mem[4] !== 32'hCAFE_5A44 || lat !== 4) begin
         errors++; $display("FAIL bst_word got %h lat %0d exp cafe5a44 lat 4", mem[4], lat);
      end
      checks++;
   endtask

   task automatic test_error;
      int lat;
      logic [31:0] rd;
      logic er;
      int rs, ws;
      poke(4, 32'h1122_3344);
      rs = rd_cnt;
      ws = wr_cnt;
      run_req(1'b0, SZ_WORD, 1'b0, 11'h013, 32'h0, lat, rd, er);
`ifdef MEM_ACCESS_ERR_CHECK_EN
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
         errors++; $display("FAIL err_word got err %b data %h lat %0d exp 1/0/1", er, rd, lat);
      end
      checks++;
      run_req(1'b0, SZ_HALF, 1'b0, 11'h011, 32'h0, lat, rd, er);
      if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_half got err %b lat %0d exp 1/1", er, lat); end
      checks++;
      run_req(1'b1, SZ_ILL, 1'b0, 11'h010, 32'h5555_5555, lat, rd, er);
      if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_size got err %b lat %0d exp 1/1", er, lat); end
      checks++;
      if (rd_cnt - rs !== 0 || wr_cnt - ws !== 0) begin
         errors++; $display("FAIL err_strobes got rd %0d wr %0d exp 0/0", rd_cnt - rs, wr_cnt - ws);
      end
      checks++;
`else
      if (er !== 1'b0 || rd !== 32'h1122_3344 || lat !== 3) begin
         errors++; $display("FAIL noerr_word got err %b data %h lat %0d exp 0/11223344/3", er, rd, lat);
      end
      checks++;
      run_req(1'b0, SZ_HALF, 1'b0, 11'h013, 32'h0, lat, rd, er);
      if (er !== 1'b0 || rd !== 32'h0000_1122) begin
         errors++; $display("FAIL noerr_half got err %b data %h exp 0/00001122", er, rd);
      end
      checks++;
      run_req(1'b0, SZ_ILL, 1'b0, 11'h012, 32'h0, lat, rd, er);
      if (er !== 1'b0 || rd !== 32'h1122_3344) begin
         errors++; $display("FAIL noerr_size got err %b data %h exp 0/11223344", er, rd);
      end
      checks++;
`endif
      run_req(1'b0, SZ_BYTE, 1'b0, 11'h013, 32'h0, lat, rd, er);
      if (er !== 1'b0 || rd !== 32'h0000_0011 || lat !== 3) begin
         errors++; $display("FAIL byte_any_offset got err %b data %h lat %0d exp 0/11/3", er, rd, lat);
      end
      checks++;
   endtask

   task automatic test_reset_mid;
      logic ok;
      int rs, ws, rc;
      poke(6, 32'h1122_3344);
      ws = wr_cnt;
      rc = rsp_cnt;
      // Byte store: reset while in MERGE
      accept_req(1'b1, SZ_BYTE, 1'b0, 11'h019, 32'h0000_00AA, ok);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", bus.req_ready); end
      checks++;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      if (!ok || wr_cnt - ws !== 0 || rsp_cnt - rc !== 0) begin
         errors++; $display("FAIL rmid_activity got ok %b wr %0d rsp %0d exp 1/0/0", ok, wr_cnt - ws, rsp_cnt - rc);
      end
      checks++;
      if (mem[6] !== 32'h1122_3344) begin errors++; $display("FAIL rmid_ram got %h exp 11223344", mem[6]); end
      checks++;
      // Load: reset while ram_read is up must drop the strobe at once
      rs = rd_cnt;
      rc = rsp_cnt;
      accept_req(1'b0, SZ_WORD, 1'b0, 11'h018, 32'h0, ok);
      reset = 1'b1;
      #1;
      if (!ok || ram_read !== 1'b0) begin errors++; $display("FAIL rmid_read_kill got ok %b ram_read %b exp 1/0", ok, ram_read); end
      checks++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      if (rd_cnt - rs !== 0 || rsp_cnt - rc !== 0) begin
         errors++; $display("FAIL rmid_load_activity got rd %0d rsp %0d exp 0/0", rd_cnt - rs, rsp_cnt - rc);
      end
      checks++;
   endtask

   task automatic test_back_to_back;
      int acc [4];
      int lat;
      logic [31:0] rd;
      logic er;
      logic got;
      for (int i = 0; i < 4; i++) poke(10 + i, 32'hA5A5_0000 | 32'(i * 17));
      @(negedge clk);
      bus.req_write = 1'b0;
      bus.req_size = SZ_WORD;
      bus.req_signed = 1'b0;
      bus.req_addr = 11'(10 * 4);
      bus.req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         got = 1'b0;
         for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
               @(posedge clk);
               #1;
               got = 1'b1;
            end
         end
         acc[i] = cyc;
         if (i < 3) bus.req_addr = 11'((11 + i) * 4);
         else bus.req_valid = 1'b0;
         if (got) wait_rsp(lat, rd, er);
         else lat = 0;
         if (!got || rd !== (32'hA5A5_0000 | 32'(i * 17)) || lat !== 3) begin
            errors++; $display("FAIL b2b_%0d got acc %b data %h lat %0d exp %h lat 3", i, got, rd, lat, 32'hA5A5_0000 | 32'(i * 17));
         end
         checks++;
         if (i > 0) begin
            if (acc[i] - acc[i-1] !== 4) begin
               errors++; $display("FAIL b2b_spacing_%0d got %0d exp 4", i, acc[i] - acc[i-1]);
            end
            checks++;
         end
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      if (max_out !== 1) begin errors++; $display("FAIL outstanding_max got %0d exp 1", max_out); end
      checks++;
      if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap got %0d exp 0", both_cnt); end
      checks++;
   endtask

   initial begin
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_size = SZ_BYTE;
      bus.req_signed = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      repeat (2) @(posedge clk);
      test_reset;
      @(negedge clk);
      reset = 1'b0;
      test_load;
      test_word_store;
      test_subword_store;
      test_error;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
